// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register-bank responder: independent write (AW/W buffers + B) and read
// (AR -> R, 1-cycle latency) paths over P_NUM_REGS word registers, exported flat on reg_q.
module axi4_lite_slave_regs #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_NUM_REGS   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               awvalid,
    output logic                               awready,
    input  logic [P_ADDR_WIDTH-1:0]            awaddr,
    input  logic [2:0]                         awprot,
    input  logic                               wvalid,
    output logic                               wready,
    input  logic [P_DATA_WIDTH-1:0]            wdata,
    input  logic [P_DATA_WIDTH/8-1:0]          wstrb,
    output logic                               bvalid,
    input  logic                               bready,
    output logic [2:0]                         bresp,
    input  logic                               arvalid,
    output logic                               arready,
    input  logic [P_ADDR_WIDTH-1:0]            araddr,
    input  logic [2:0]                         arprot,
    output logic                               rvalid,
    input  logic                               rready,
    output logic [P_DATA_WIDTH-1:0]            rdata,
    output logic [2:0]                         rresp,
    output logic [P_NUM_REGS*P_DATA_WIDTH-1:0] reg_q
);

    localparam int STRB_W = P_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = P_ADDR_WIDTH - LSB;
    localparam int SEL_W  = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;

    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;

    logic [P_DATA_WIDTH-1:0] regs_q [P_NUM_REGS];
    logic [P_DATA_WIDTH-1:0] regs_d [P_NUM_REGS];

    logic                    aw_full_q, aw_full_d;
    logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
    logic                    w_full_q, w_full_d;
    logic [P_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]       w_strb_q, w_strb_d;
    logic                    bvalid_q, bvalid_d;
    logic [2:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]              rresp_q, rresp_d;

    logic             aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_ok;

    assign awready = !aw_full_q && !bvalid_q;
    assign wready  = !w_full_q && !bvalid_q;
    assign arready = !rvalid_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign ar_idx = araddr[P_ADDR_WIDTH-1:LSB];

    assign unused_ok = ^{awprot, arprot, awaddr, araddr};

    always_comb begin
        for (int unsigned i = 0; i < P_NUM_REGS; i++) begin
            reg_q[i*P_DATA_WIDTH +: P_DATA_WIDTH] = regs_q[i];
        end
    end

    always_comb begin
        regs_d    = regs_q;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = awaddr[P_ADDR_WIDTH-1:LSB];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        // Both buffers full implies bvalid_q is low, so commit never overlaps a pending B.
        if (aw_full_q && w_full_q) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (aw_idx_q < IDX_W'(P_NUM_REGS)) begin
                bresp_d = RESP_OKAY;
                for (int unsigned k = 0; k < STRB_W; k++) begin
                    if (w_strb_q[k]) begin
                        regs_d[aw_idx_q[SEL_W-1:0]][k*8 +: 8] = w_data_q[k*8 +: 8];
                    end
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        // Read samples regs_q, so a same-edge commit is not visible to it.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (ar_idx < IDX_W'(P_NUM_REGS)) begin
                rdata_d = regs_q[ar_idx[SEL_W-1:0]];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < P_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Bench for axi4_lite_slave_regs: transaction-level reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_axi4_lite_slave_regs;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]  awaddr = '0, araddr = '0, wdata = '0;
    logic [3:0]   wstrb = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [2:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [511:0] reg_q;

    int vectors = 0;
    int errors  = 0;

    axi4_lite_slave_regs #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(32), .P_NUM_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending-transaction flags and a word memory.
    logic [31:0] m_mem [16];
    bit          m_aw_have, m_w_have, m_b, m_r;
    logic [29:0] m_aw_word, m_ar_word;
    logic [31:0] m_wd, m_rdata;
    logic [3:0]  m_ws;
    logic [2:0]  m_bresp, m_rresp;
    bit          m_aw_take, m_w_take, m_ar_take, m_commit;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_aw_have = 0; m_w_have = 0; m_b = 0; m_r = 0;
        end else begin
            m_aw_take = awvalid && !m_aw_have && !m_b;
            m_w_take  = wvalid && !m_w_have && !m_b;
            m_ar_take = arvalid && !m_r;
            m_commit  = m_aw_have && m_w_have;
            if (m_ar_take) begin
                m_ar_word = araddr[31:2];
                m_r = 1;
                if (m_ar_word < 16) begin m_rdata = m_mem[m_ar_word]; m_rresp = 3'b000; end
                else begin m_rdata = '0; m_rresp = 3'b010; end
            end else if (m_r && rready) begin
                m_r = 0;
            end
            if (m_commit) begin
                if (m_aw_word < 16) begin
                    for (int k = 0; k < 4; k++)
                        if (m_ws[k]) m_mem[m_aw_word][8*k +: 8] = m_wd[8*k +: 8];
                    m_bresp = 3'b000;
                end else begin
                    m_bresp = 3'b010;
                end
                m_b = 1; m_aw_have = 0; m_w_have = 0;
            end else if (m_b && bready) begin
                m_b = 0;
            end
            if (m_aw_take) begin m_aw_have = 1; m_aw_word = awaddr[31:2]; end
            if (m_w_take)  begin m_w_have = 1; m_wd = wdata; m_ws = wstrb; end
        end
    end

    logic [511:0] m_flat;
    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) m_flat[32*i +: 32] = m_mem[i];
        chk("awready", awready, !m_aw_have && !m_b);
        chk("wready",  wready,  !m_w_have && !m_b);
        chk("arready", arready, !m_r);
        chk("bvalid",  bvalid,  m_b);
        chk("rvalid",  rvalid,  m_r);
        if (m_b) chk("bresp", bresp, m_bresp);
        if (m_r) begin
            chk("rdata", rdata, m_rdata);
            chk("rresp", rresp, m_rresp);
        end
        chk("reg_q", reg_q, m_flat);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [2:0] resp);
        bit a_rdy, w_rdy;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            a_rdy = awready; w_rdy = wready;
            step();
            if (a_rdy) awvalid = 0;
            if (w_rdy) wvalid = 0;
        end
        chk("wr_accept", {awvalid, wvalid}, 2'b00);
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 20 && !bvalid; i++) step();
        chk("wr_bvalid_wait", bvalid, 1'b1);
        resp = bresp;
        bready = 1; step(); bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [2:0] resp);
        bit r_rdy;
        araddr = a; arvalid = 1;
        for (int i = 0; i < 20 && arvalid; i++) begin
            r_rdy = arready;
            step();
            if (r_rdy) arvalid = 0;
        end
        chk("rd_accept", arvalid, 1'b0);
        arvalid = 0;
        for (int i = 0; i < 20 && !rvalid; i++) step();
        chk("rd_rvalid_wait", rvalid, 1'b1);
        d = rdata; resp = rresp;
        rready = 1; step(); rready = 0;
    endtask

    logic [2:0]   resp;
    logic [31:0]  data;
    logic [511:0] snap;

    initial begin
        step(); step();
        rst = 0;
        chk("rst_ready", {awready, wready, arready}, 3'b111);
        chk("rst_valid", {bvalid, rvalid}, 2'b00);
        chk("rst_resp_data", {bresp, rresp, rdata}, '0);
        chk("rst_regs", reg_q, '0);

        // 1) AW and W together
        awaddr = 32'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        chk("t1_ready", {awready, wready}, 2'b11);
        step(); awvalid = 0; wvalid = 0;
        chk("t1_b_early", bvalid, 1'b0);
        step();
        chk("t1_bvalid", bvalid, 1'b1);
        chk("t1_bresp", bresp, 3'b000);
        chk("t1_reg1", reg_q[63:32], 32'hDEADBEEF);
        chk("t1_aw_blocked", awready, 1'b0);
        bready = 1; step(); bready = 0;
        chk("t1_bclr", {bvalid, awready, wready}, 3'b011);

        // 2) W two cycles ahead of AW, partial strobes over 0xFFFFFFFF
        do_write(32'h8, 32'hFFFFFFFF, 4'hF, resp);
        wdata = 32'h12345678; wstrb = 4'b0101; wvalid = 1;
        step(); wvalid = 0;
        chk("t2_wready_low", wready, 1'b0);
        step(); step();
        chk("t2_wready_still_low", wready, 1'b0);
        awaddr = 32'h8; awvalid = 1;
        step(); awvalid = 0;
        chk("t2_commit_cycle", {bvalid, wready}, 2'b00);
        step();
        chk("t2_bvalid", bvalid, 1'b1);
        chk("t2_reg2", reg_q[95:64], 32'hFF34FF78);
        chk("t2_wready_during_b", wready, 1'b0);
        bready = 1; step(); bready = 0;
        chk("t2_wready_back", wready, 1'b1);

        // 3) Read with back-pressure
        araddr = 32'h4; arvalid = 1;
        step(); arvalid = 0;
        chk("t3_rvalid", rvalid, 1'b1);
        chk("t3_arready", arready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_rdata_stable", rdata, 32'hDEADBEEF);
            step();
        end
        chk("t3_rvalid_held", rvalid, 1'b1);
        rready = 1; step(); rready = 0;
        chk("t3_rclr", {rvalid, arready}, 2'b01);

        // 4) Out-of-range index
        snap = reg_q;
        do_write(32'h40, 32'h11111111, 4'hF, resp);
        chk("t4_bresp", resp, 3'b010);
        do_read(32'h40, data, resp);
        chk("t4_rresp", resp, 3'b010);
        chk("t4_rdata", data, 32'h0);
        chk("t4_regs_unchanged", reg_q, snap);

        // Unaligned addresses, last register, empty strobe
        do_write(32'h37, 32'h1122AB44, 4'b0010, resp);
        do_read(32'h35, data, resp);
        chk("unaligned_rd", data, 32'h0000AB00);
        do_write(32'h3C, 32'hCAFEF00D, 4'b1100, resp);
        do_read(32'h3F, data, resp);
        chk("last_reg_rd", data, 32'hCAFE0000);
        do_write(32'h4, 32'h0, 4'b0000, resp);
        chk("zero_strb_resp", resp, 3'b000);
        chk("zero_strb_reg1", reg_q[63:32], 32'hDEADBEEF);

        // 5) Read capture on the commit edge sees the old value
        awaddr = 32'h0; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step(); awvalid = 0; wvalid = 0;
        araddr = 32'h0; arvalid = 1;
        step(); arvalid = 0;
        chk("t5_rvalid_bvalid", {rvalid, bvalid}, 2'b11);
        chk("t5_rdata_old", rdata, 32'h0);
        chk("t5_reg0", reg_q[31:0], 32'hA5A5A5A5);
        rready = 1; bready = 1; step(); rready = 0; bready = 0;
        do_read(32'h0, data, resp);
        chk("t5_rdata_new", data, 32'hA5A5A5A5);

        // 6) Reset with AW buffered and R pending
        awaddr = 32'hC; awvalid = 1;
        step(); awvalid = 0;
        araddr = 32'h4; arvalid = 1;
        step(); arvalid = 0;
        chk("t6_pre_rvalid", {rvalid, awready}, 2'b10);
        rst = 1; step(); rst = 0;
        chk("t6_valids", {bvalid, rvalid}, 2'b00);
        chk("t6_readies", {awready, wready, arready}, 3'b111);
        chk("t6_regs", reg_q, '0);
        chk("t6_rdata", rdata, 32'h0);
        wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1;
        step(); wvalid = 0;
        step(); step();
        chk("t6_no_b", bvalid, 1'b0);
        chk("t6_no_write", reg_q, '0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
